// File: rtl/scan_pkg.sv
// Shared state type, constants and leading-zero blanking helper for the
// multiplexed four-digit scan controller.
package scan_pkg;

  localparam int         NUM_DIGITS    = 4;
  localparam logic [3:0] SEL_OFF       = 4'hF;
  localparam int         TICK_DIV_DEF  = 50000;
  localparam int         BLANK_CYC_DEF = 500;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  // A digit is dark only if it and every more-significant digit are plain zeros.
  function automatic logic [3:0] blank_mask(input logic [15:0] digits,
                                            input logic [3:0]  dp,
                                            input logic        lz);
    logic [3:0] mask;
    mask[3] = lz && (digits[15:12] == 4'd0) && !dp[3];
    mask[2] = mask[3] && (digits[11:8] == 4'd0) && !dp[2];
    mask[1] = mask[2] && (digits[7:4] == 4'd0) && !dp[1];
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Down-counter timing one SHOW or GAP interval: load with length-1, done at zero.
module scan_slot_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_r;

  // Clear wins over load; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
    end
  end

  assign done = (count_r == '0);

endmodule

// File: rtl/digit_scan_controller.sv
// Time-multiplexed anode scanner for a four-digit common-anode display with
// per-frame input snapshot, leading-zero blanking and an anode-off guard gap.
module digit_scan_controller
  import scan_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [3:0]  BCD_out,
  output logic        dp_out,
  output logic [3:0]  SEL,
  output logic [1:0]  digit_idx,
  output logic        frame_start
);

  localparam int               CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(TICK_DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  logic [1:0]       rst_sync_r;
  scan_state_e      state_r, state_nxt_s;
  logic [1:0]       idx_r, idx_nxt_s;
  logic [15:0]      snap_digits_r, src_digits_s;
  logic [3:0]       snap_dp_r, src_dp_s, mask_s;
  logic             snap_lz_r, src_lz_s, snap_load_s;
  logic [3:0]       sel_r, sel_nxt_s, bcd_r, bcd_nxt_s;
  logic             dp_r, dp_nxt_s, frame_start_r;
  logic             tmr_clear_s, tmr_load_s, tmr_done_s;
  logic [CNT_W-1:0] tmr_val_s;

  // Two-flop release of the reset; the FSM stays in IDLE until it completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  scan_slot_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear_s),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Next state, slot index and timer control.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    snap_load_s = 1'b0;
    tmr_clear_s = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = SHOW_LD;
    if (!rst_sync_r[1] || !enable) begin
      state_nxt_s = IDLE;
      idx_nxt_s   = 2'd0;
      tmr_clear_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = SHOW;
          idx_nxt_s   = 2'd0;
          snap_load_s = 1'b1;
          tmr_load_s  = 1'b1;
        end
        SHOW: begin
          if (tmr_done_s && (BLANK_CYC == 0)) begin
            idx_nxt_s   = idx_r + 2'd1;
            snap_load_s = (idx_r == 2'd3);
            tmr_load_s  = 1'b1;
          end else if (tmr_done_s) begin
            state_nxt_s = GAP;
            tmr_load_s  = 1'b1;
            tmr_val_s   = GAP_LD;
          end else begin
            state_nxt_s = SHOW;
          end
        end
        GAP: begin
          if (tmr_done_s) begin
            state_nxt_s = SHOW;
            idx_nxt_s   = idx_r + 2'd1;
            snap_load_s = (idx_r == 2'd3);
            tmr_load_s  = 1'b1;
          end else begin
            state_nxt_s = GAP;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          idx_nxt_s   = 2'd0;
          tmr_clear_s = 1'b1;
        end
      endcase
    end
  end

  // The first SHOW cycle of a frame must already display the data being latched.
  always_comb begin
    src_digits_s = snap_load_s ? digits_in : snap_digits_r;
    src_dp_s     = snap_load_s ? dp_in     : snap_dp_r;
    src_lz_s     = snap_load_s ? lz_blank  : snap_lz_r;
    mask_s       = blank_mask(src_digits_s, src_dp_s, src_lz_s);
    case (state_nxt_s)
      SHOW: begin
        sel_nxt_s = mask_s[idx_nxt_s] ? SEL_OFF : ~(4'b0001 << idx_nxt_s);
        bcd_nxt_s = src_digits_s[{idx_nxt_s, 2'b00} +: 4];
        dp_nxt_s  = src_dp_s[idx_nxt_s];
      end
      GAP: begin
        sel_nxt_s = SEL_OFF;
        bcd_nxt_s = bcd_r;
        dp_nxt_s  = dp_r;
      end
      default: begin
        sel_nxt_s = SEL_OFF;
        bcd_nxt_s = 4'd0;
        dp_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      idx_r         <= 2'd0;
      snap_digits_r <= 16'd0;
      snap_dp_r     <= 4'd0;
      snap_lz_r     <= 1'b0;
      sel_r         <= SEL_OFF;
      bcd_r         <= 4'd0;
      dp_r          <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      sel_r         <= sel_nxt_s;
      bcd_r         <= bcd_nxt_s;
      dp_r          <= dp_nxt_s;
      frame_start_r <= snap_load_s;
      if (snap_load_s) begin
        snap_digits_r <= digits_in;
        snap_dp_r     <= dp_in;
        snap_lz_r     <= lz_blank;
      end
    end
  end

  assign SEL         = sel_r;
  assign BCD_out     = bcd_r;
  assign dp_out      = dp_r;
  assign digit_idx   = idx_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Directed bench for digit_scan_controller (TICK_DIV=10, BLANK_CYC=2) plus a
// gapless BLANK_CYC=0 build sharing the same inputs.
module tb_digit_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n, enable, lz_blank;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  BCD_out, SEL, bcd_ng, sel_ng;
  logic        dp_out, frame_start, dp_ng, fs_ng;
  logic [1:0]  digit_idx, idx_ng;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  digit_scan_controller #(.TICK_DIV(10), .BLANK_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .lz_blank(lz_blank), .BCD_out(BCD_out), .dp_out(dp_out),
    .SEL(SEL), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  digit_scan_controller #(.TICK_DIV(10), .BLANK_CYC(0)) u_dut_nogap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .lz_blank(lz_blank), .BCD_out(bcd_ng), .dp_out(dp_ng),
    .SEL(sel_ng), .digit_idx(idx_ng), .frame_start(fs_ng)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the current cycle, then find the next frame_start (bounded).
  task automatic wait_next_frame();
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_wait", frame_start, 32'd1);
  endtask

  // Called on the first cycle of a frame; checks all 40 cycles and the next frame_start.
  task automatic check_frame(input string name, input logic [15:0] esel,
                             input logic [15:0] ebcd, input logic [3:0] edp,
                             input int chg_at, input logic [15:0] chg_val);
    for (int c = 0; c < 40; c++) begin
      int k = c / 10;
      int s = c % 10;
      check_eq($sformatf("%s sel c%0d", name, c), SEL, (s < 8) ? esel[k*4 +: 4] : 4'hF);
      check_eq($sformatf("%s bcd c%0d", name, c), BCD_out, ebcd[k*4 +: 4]);
      check_eq($sformatf("%s dp c%0d", name, c), dp_out, edp[k]);
      check_eq($sformatf("%s idx c%0d", name, c), digit_idx, k);
      check_eq($sformatf("%s fs c%0d", name, c), frame_start, (c == 0));
      if (c == chg_at) digits_in = chg_val;
      @(negedge clk);
    end
    check_eq($sformatf("%s period", name), frame_start, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; digits_in = 16'h1234; dp_in = 4'h0; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst sel", SEL, 32'hF);
    check_eq("rst bcd", BCD_out, 32'h0);
    check_eq("rst dp", dp_out, 32'h0);
    check_eq("rst idx", digit_idx, 32'h0);
    check_eq("rst fs", frame_start, 32'h0);
    check_eq("rst sel_ng", sel_ng, 32'hF);

    // Release with enable high: first SHOW appears after the third edge.
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);
    check_eq("rel1 fs", frame_start, 32'h0);
    check_eq("rel1 sel", SEL, 32'hF);
    @(negedge clk);
    check_eq("rel2 fs", frame_start, 32'h0);
    check_eq("rel2 sel", SEL, 32'hF);
    @(negedge clk);
    check_eq("rel3 fs", frame_start, 32'h1);
    check_frame("s1234", 16'h7BDE, 16'h1234, 4'h0, -1, 16'h0);

    for (int c = 0; c < 40; c++) begin
      check_eq($sformatf("nogap sel_f c%0d", c), (sel_ng == 4'hF), 32'h0);
      check_eq($sformatf("nogap onehot c%0d", c), $countones(~sel_ng), 32'd1);
      @(negedge clk);
    end

    digits_in = 16'h0050; lz_blank = 1'b1;
    wait_next_frame();
    check_frame("lz0050", 16'hFFDE, 16'h0050, 4'h0, -1, 16'h0);

    digits_in = 16'h0007; dp_in = 4'b0100;
    wait_next_frame();
    check_frame("lz0007dp", 16'hFBDE, 16'h0007, 4'b0100, -1, 16'h0);

    digits_in = 16'h0A00; dp_in = 4'h0;
    wait_next_frame();
    check_frame("lz0A00", 16'hFBDE, 16'h0A00, 4'h0, -1, 16'h0);

    digits_in = 16'h0000;
    wait_next_frame();
    check_frame("lz0000", 16'hFFFE, 16'h0000, 4'h0, -1, 16'h0);

    digits_in = 16'h1111; lz_blank = 1'b0;
    wait_next_frame();
    check_frame("mid1", 16'h7BDE, 16'h1111, 4'h0, 15, 16'h2222);
    check_frame("mid2", 16'h7BDE, 16'h2222, 4'h0, -1, 16'h0);

    // Drop enable during SHOW of digit 2.
    digits_in = 16'h1234;
    wait_next_frame();
    repeat (23) @(negedge clk);
    check_eq("drop pre sel", SEL, 32'hB);
    enable = 1'b0;
    @(negedge clk);
    check_eq("drop sel", SEL, 32'hF);
    check_eq("drop idx", digit_idx, 32'h0);
    check_eq("drop bcd", BCD_out, 32'h0);
    check_eq("drop fs", frame_start, 32'h0);
    repeat (5) @(negedge clk);
    check_eq("idle sel", SEL, 32'hF);
    enable = 1'b1;
    @(negedge clk);
    check_eq("reen fs", frame_start, 32'h1);
    check_eq("reen idx", digit_idx, 32'h0);
    check_eq("reen sel", SEL, 32'hE);
    check_frame("reen", 16'h7BDE, 16'h1234, 4'h0, -1, 16'h0);

    // Asynchronous reset during the GAP of digit 0.
    repeat (8) @(negedge clk);
    check_eq("gap pre sel", SEL, 32'hF);
    check_eq("gap pre bcd", BCD_out, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst sel", SEL, 32'hF);
    check_eq("arst bcd", BCD_out, 32'h0);
    check_eq("arst dp", dp_out, 32'h0);
    check_eq("arst idx", digit_idx, 32'h0);
    check_eq("arst fs", frame_start, 32'h0);
    digits_in = 16'h0000; lz_blank = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel2a fs", frame_start, 32'h0);
    @(negedge clk);
    check_eq("rel2b fs", frame_start, 32'h0);
    @(negedge clk);
    check_eq("rel2c fs", frame_start, 32'h1);
    check_frame("post_rst", 16'hFFFE, 16'h0000, 4'h0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
